// File: rtl/imem_responder.sv
// Instruction-fetch memory responder: word array, fetch FSM with programmable wait states, and a side load port.
// Latency: a request accepted in cycle T is answered with a one-cycle imem_data_valid strobe in cycle T+1+LATENCY.
// Backpressure: none on the response; the requester holds imem_addr_valid until the strobe, and dropping it early aborts.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   imem_addr         fetch byte address, held while imem_addr_valid=1
//   imem_addr_valid   level request, held until imem_data_valid
//   imem_data         fetched word, zero outside the response cycle
//   imem_data_valid   one-cycle response strobe
//   imem_fault        set with imem_data_valid when the request faulted
//   load_we           write one word into storage
//   load_addr         byte address of the load word, bits [2:0] ignored
//   load_data         word to write
//   resp_count        completed responses, wraps at 2^32
module imem_responder #(
  parameter int unsigned NUM_BYTES = 256,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] ADDR_BASE = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] imem_addr,
  input  logic        imem_addr_valid,
  output logic [63:0] imem_data,
  output logic        imem_data_valid,
  output logic        imem_fault,
  input  logic        load_we,
  input  logic [63:0] load_addr,
  input  logic [63:0] load_data,
  output logic [31:0] resp_count
);

  localparam int unsigned NUM_WORDS   = NUM_BYTES / 8;
  localparam int unsigned IDX_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [60:0] NUM_WORDS_W = 61'(NUM_WORDS);
  localparam logic [3:0]  LAT         = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Storage: never reset, so a bench- or boot-loaded image survives rst.
  logic [63:0] mem_q [NUM_WORDS];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] word_q, word_d;
  logic        fault_q, fault_d;
  logic [31:0] resp_count_q, resp_count_d;

  // ---------------------------------------------------------------------
  // Fetch address decode
  // ---------------------------------------------------------------------
  // A 65-bit subtraction exposes the borrow, which flags addresses below
  // ADDR_BASE without a constant compare when the base is zero.
  logic [64:0]      fetch_diff;
  logic [63:0]      fetch_off;
  logic [60:0]      fetch_word_off;
  logic             fetch_fault;
  logic [IDX_W-1:0] fetch_idx;
  logic [63:0]      fetch_word;

  always_comb begin
    fetch_diff     = {1'b0, imem_addr} - {1'b0, ADDR_BASE};
    fetch_off      = fetch_diff[63:0];
    fetch_word_off = fetch_off[63:3];
    fetch_idx      = fetch_word_off[IDX_W-1:0];
    // ADDR_BASE is 8-byte aligned, so the offset's low bits equal the
    // address's low bits and serve as the misalignment test.
    fetch_fault    = (fetch_off[2:0] != 3'b000)
                   || fetch_diff[64]
                   || (fetch_word_off >= NUM_WORDS_W);
    // A faulting request never touches storage and returns zero.
    fetch_word     = fetch_fault ? 64'h0 : mem_q[fetch_idx];
  end

  // ---------------------------------------------------------------------
  // Load port decode
  // ---------------------------------------------------------------------
  logic [64:0]      load_diff;
  logic [63:0]      load_off;
  logic [60:0]      load_word_off;
  logic             mem_wr_en_d;
  logic [IDX_W-1:0] mem_wr_idx_d;
  logic [63:0]      mem_wr_dat_d;
  logic             unused_load_lsb;

  always_comb begin
    load_diff     = {1'b0, load_addr} - {1'b0, ADDR_BASE};
    load_off      = load_diff[63:0];
    load_word_off = load_off[63:3];
    mem_wr_idx_d  = load_word_off[IDX_W-1:0];
    mem_wr_dat_d  = load_data;
    // Out-of-range loads are dropped without any indication.
    mem_wr_en_d   = load_we && !load_diff[64] && (load_word_off < NUM_WORDS_W);
  end

  // Byte-within-word bits of a load address carry no meaning.
  assign unused_load_lsb = ^load_off[2:0];

  // Write lands at the clock edge; a fetch accepted in the same cycle has
  // already captured the old word through the combinational read above.
  always_ff @(posedge clk) begin
    if (mem_wr_en_d) begin
      mem_q[mem_wr_idx_d] <= mem_wr_dat_d;
    end
  end

  // ---------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    fault_d      = fault_q;
    resp_count_d = resp_count_q;

    case (state_q)
      S_IDLE: begin
        if (imem_addr_valid) begin
          // Read data and fault are frozen here; later loads cannot
          // change what this request returns.
          word_d  = fetch_word;
          fault_d = fetch_fault;
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? S_RESP : S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!imem_addr_valid) begin
          // Requester withdrew: abandon silently, nothing counted.
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        resp_count_d = resp_count_q + 32'd1;
        // Always revisit IDLE so a still-held request is treated as new.
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      word_q       <= 64'h0;
      fault_q      <= 1'b0;
      resp_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      fault_q      <= fault_d;
      resp_count_q <= resp_count_d;
    end
  end

  // Outputs are gated by the RESP state so they read zero in every other
  // cycle, including straight after reset or an abort.
  assign imem_data_valid = (state_q == S_RESP);
  assign imem_data       = imem_data_valid ? word_q : 64'h0;
  assign imem_fault      = imem_data_valid && fault_q;
  assign resp_count      = resp_count_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: one instance with LATENCY=2 and one with LATENCY=0.
// Expected responses are queued as stimulus is driven and matched against each strobe.
// Ends with a single summary line.
module tb_imem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] addr  [2];
  logic        avld  [2];
  logic        lwe   [2];
  logic [63:0] laddr [2];
  logic [63:0] ldat  [2];
  logic [63:0] data  [2];
  logic        dv    [2];
  logic        flt   [2];
  logic [31:0] cnt   [2];

  // Instance 0: zero wait states.  Instance 1: two wait states.
  imem_responder #(.NUM_BYTES(256), .LATENCY(0), .ADDR_BASE(64'h0)) u_dut0 (
    .clk(clk), .rst(rst),
    .imem_addr(addr[0]), .imem_addr_valid(avld[0]),
    .imem_data(data[0]), .imem_data_valid(dv[0]), .imem_fault(flt[0]),
    .load_we(lwe[0]), .load_addr(laddr[0]), .load_data(ldat[0]),
    .resp_count(cnt[0])
  );

  imem_responder #(.NUM_BYTES(256), .LATENCY(2), .ADDR_BASE(64'h0)) u_dut1 (
    .clk(clk), .rst(rst),
    .imem_addr(addr[1]), .imem_addr_valid(avld[1]),
    .imem_data(data[1]), .imem_data_valid(dv[1]), .imem_fault(flt[1]),
    .load_we(lwe[1]), .load_addr(laddr[1]), .load_data(ldat[1]),
    .resp_count(cnt[1])
  );

  typedef struct {
    logic [63:0] data;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t        exp_q0 [$];
  exp_t        exp_q1 [$];
  logic [63:0] mdl [2][32];
  int          exp_cnt [2];
  int          lat [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t predict(input int d, input logic [63:0] a, input int c);
    exp_t e;
    e.cyc = c;
    if (a[2:0] != 3'b000 || a >= 64'd256) begin
      e.fault = 1'b1;
      e.data  = 64'h0;
    end else begin
      e.fault = 1'b0;
      e.data  = mdl[d][a[7:3]];
    end
    return e;
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic mdl_write(input int d, input logic [63:0] a, input logic [63:0] v);
    if (a < 64'd256) mdl[d][a[7:3]] = v;
  endtask

  // One-cycle load; the model is updated after the cycle so any fetch
  // accepted in that same cycle has already been predicted from old data.
  task automatic load(input int d, input logic [63:0] a, input logic [63:0] v);
    lwe[d]   = 1'b1;
    laddr[d] = a;
    ldat[d]  = v;
    tick();
    lwe[d]   = 1'b0;
    mdl_write(d, a, v);
  endtask

  task automatic wait_resp(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dv[d] && n < 40);
    if (!dv[d]) check("resp_timeout", 64'(dv[d]), 64'd1);
  endtask

  // Single request; caller is just past a posedge with the DUT idle.
  task automatic fetch(input int d, input logic [63:0] a);
    addr[d] = a;
    avld[d] = 1'b1;
    push(d, predict(d, a, cyc + 1 + lat[d]));
    exp_cnt[d]++;
    wait_resp(d);
    tick();
    avld[d] = 1'b0;
    check("resp_count", 64'(cnt[d]), 64'(exp_cnt[d]));
  endtask

  // Response monitor: every strobe must match the head of its queue,
  // including the exact cycle; outputs must be zero when not strobing.
  task automatic monitor(input int d);
    exp_t e;
    if (dv[d]) begin
      if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
        check("spurious_resp", 64'(dv[d]), 64'd0);
      end else begin
        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check("resp_data",  data[d],      e.data);
        check("resp_fault", 64'(flt[d]),  64'(e.fault));
        check("resp_cycle", 64'(cyc),     64'(e.cyc));
      end
    end else begin
      check("idle_outputs", {data[d][63:1], data[d][0] | flt[d]}, 64'h0);
    end
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0;
    lat[0] = 0;
    lat[1] = 2;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; avld[d] = 1'b0; lwe[d] = 1'b0; laddr[d] = '0; ldat[d] = '0;
      exp_cnt[d] = 0;
      for (int i = 0; i < 32; i++) mdl[d][i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;

    // Fill both memories with distinct patterns.
    for (int i = 0; i < 32; i++) begin
      load(0, 64'(i * 8), 64'hC0DE_0000_0000_0000 | 64'(i));
      load(1, 64'(i * 8), 64'hBEEF_0001_0000_0000 | 64'(i * 3));
    end

    // Reset values; storage must survive reset.
    load(1, 64'h0, 64'h0123456789ABCDEF);
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid", 64'(dv[1]),  64'd0);
    check("rst_fault", 64'(flt[1]), 64'd0);
    check("rst_count", 64'(cnt[1]), 64'd0);
    check("rst_data",  data[1],     64'h0);
    rst = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    tick();
    fetch(1, 64'h0);

    // Two wait states: exact response cycle checked by the monitor.
    fetch(1, 64'h8);
    fetch(1, 64'hF8);

    // Zero wait states with the request held across three fetches.
    addr[0] = 64'h0;
    avld[0] = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      push(0, predict(0, 64'(k * 8), t0 + 1 + 2 * k));
      exp_cnt[0]++;
      wait_resp(0);
      tick();
      if (k < 2) addr[0] = 64'((k + 1) * 8);
      else       avld[0] = 1'b0;
    end
    check("b2b_count", 64'(cnt[0]), 64'd3);

    // Faults: misaligned, one past the end, and far out of range.
    fetch(1, 64'h4);
    fetch(1, 64'h100);
    fetch(1, 64'hFFFF_FFFF_FFFF_FFF8);
    fetch(0, 64'h3);

    // Out-of-range load must not alias onto word 0.
    load(1, 64'h100, 64'hDEAD_DEAD_DEAD_DEAD);
    fetch(1, 64'h0);

    // Abort during WAIT: no response, count unchanged.
    addr[1] = 64'h10;
    avld[1] = 1'b1;
    tick();
    avld[1] = 1'b0;
    repeat (5) tick();
    check("abort_count", 64'(cnt[1]), 64'(exp_cnt[1]));
    fetch(1, 64'h10);

    // Load in the accept cycle returns the old word; re-fetch sees new.
    addr[1]  = 64'h18;
    avld[1]  = 1'b1;
    lwe[1]   = 1'b1;
    laddr[1] = 64'h18;
    ldat[1]  = 64'hAAAA;
    push(1, predict(1, 64'h18, cyc + 3));
    exp_cnt[1]++;
    tick();
    lwe[1] = 1'b0;
    mdl_write(1, 64'h18, 64'hAAAA);
    wait_resp(1);
    tick();
    avld[1] = 1'b0;
    fetch(1, 64'h18);

    // Load during WAIT leaves the in-flight word untouched.
    addr[1] = 64'h20;
    avld[1] = 1'b1;
    push(1, predict(1, 64'h20, cyc + 3));
    exp_cnt[1]++;
    tick();
    load(1, 64'h20, 64'h5555_6666_7777_8888);
    wait_resp(1);
    tick();
    avld[1] = 1'b0;
    fetch(1, 64'h20);

    // Reset mid-WAIT discards the request and clears the count.
    addr[1] = 64'h28;
    avld[1] = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    avld[1] = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    repeat (5) tick();
    check("rst_wait_count", 64'(cnt[1]), 64'd0);
    fetch(1, 64'h28);

    repeat (5) tick();
    check("queue_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
